// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared combinational ALU.
// Captures the granted operation's result into a one-entry response register.
module alu_arbiter #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req0_valid_i,
  output logic                  req0_ready_o,
  input  logic [DATA_WIDTH-1:0] req0_srcA_i,
  input  logic [DATA_WIDTH-1:0] req0_srcB_i,
  input  logic [3:0]            req0_ctrl_i,
  input  logic [2:0]            req0_branch_i,
  input  logic                  req1_valid_i,
  output logic                  req1_ready_o,
  input  logic [DATA_WIDTH-1:0] req1_srcA_i,
  input  logic [DATA_WIDTH-1:0] req1_srcB_i,
  input  logic [3:0]            req1_ctrl_i,
  input  logic [2:0]            req1_branch_i,
  output logic [DATA_WIDTH-1:0] alu_srcA_o,
  output logic [DATA_WIDTH-1:0] alu_srcB_o,
  output logic [3:0]            alu_ctrl_o,
  output logic [2:0]            alu_branch_o,
  input  logic [DATA_WIDTH-1:0] alu_result_i,
  input  logic                  alu_taken_i,
  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output logic                  resp_id_o,
  output logic [DATA_WIDTH-1:0] resp_result_o,
  output logic                  resp_taken_o
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t state_q, state_d;
  logic   rr_q;
  logic   grant_valid, grant_id;
  logic   accept_ok, handshake;

  // Grant depends only on valids and rr, so resp_ready_i never reaches the ALU mux.
  always_comb begin
    grant_valid = req0_valid_i | req1_valid_i;
    grant_id    = (req0_valid_i & req1_valid_i) ? rr_q : req1_valid_i;
  end

  always_comb begin
    alu_srcA_o   = '0;
    alu_srcB_o   = '0;
    alu_ctrl_o   = 4'b0000;
    alu_branch_o = 3'b010;
    if (grant_valid) begin
      if (grant_id) begin
        alu_srcA_o   = req1_srcA_i;
        alu_srcB_o   = req1_srcB_i;
        alu_ctrl_o   = req1_ctrl_i;
        alu_branch_o = req1_branch_i;
      end else begin
        alu_srcA_o   = req0_srcA_i;
        alu_srcB_o   = req0_srcB_i;
        alu_ctrl_o   = req0_ctrl_i;
        alu_branch_o = req0_branch_i;
      end
    end
  end

  always_comb begin
    accept_ok    = (state_q == EMPTY) | resp_ready_i;
    handshake    = grant_valid & accept_ok;
    req0_ready_o = handshake & ~grant_id;
    req1_ready_o = handshake & grant_id;
    resp_valid_o = (state_q == FULL);
    state_d      = state_q;
    if (handshake)
      state_d = FULL;
    else if ((state_q == FULL) && resp_ready_i)
      state_d = EMPTY;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= EMPTY;
      rr_q          <= 1'b0;
      resp_id_o     <= 1'b0;
      resp_result_o <= '0;
      resp_taken_o  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (handshake) begin
        rr_q          <= ~grant_id;
        resp_id_o     <= grant_id;
        resp_result_o <= alu_result_i;
        resp_taken_o  <= alu_taken_i;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed and randomized bench for alu_arbiter with a behavioural ALU and
// a transaction-level model of arbitration and the response slot.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        v[2];
  logic [31:0] sa[2], sb[2];
  logic [3:0]  ct[2];
  logic [2:0]  bc[2];
  logic        r0, r1;
  logic [31:0] alu_a, alu_b, alu_res;
  logic [3:0]  alu_c;
  logic [2:0]  alu_br;
  logic        alu_tk;
  logic        rdy;
  logic        resp_v, resp_id, resp_tk;
  logic [31:0] resp_res;

  int checks = 0;
  int failures = 0;

  // model state
  bit          m_full, m_id, m_taken, m_rr;
  logic [31:0] m_res;
  int          last_hs = -1;
  logic        ob_r0, ob_r1;

  always #5 clk = ~clk;

  alu_arbiter #(.DATA_WIDTH(32)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req0_valid_i(v[0]), .req0_ready_o(r0), .req0_srcA_i(sa[0]), .req0_srcB_i(sb[0]),
    .req0_ctrl_i(ct[0]), .req0_branch_i(bc[0]),
    .req1_valid_i(v[1]), .req1_ready_o(r1), .req1_srcA_i(sa[1]), .req1_srcB_i(sb[1]),
    .req1_ctrl_i(ct[1]), .req1_branch_i(bc[1]),
    .alu_srcA_o(alu_a), .alu_srcB_o(alu_b), .alu_ctrl_o(alu_c), .alu_branch_o(alu_br),
    .alu_result_i(alu_res), .alu_taken_i(alu_tk),
    .resp_valid_o(resp_v), .resp_ready_i(rdy), .resp_id_o(resp_id),
    .resp_result_o(resp_res), .resp_taken_o(resp_tk)
  );

  function automatic logic [31:0] ref_alu(logic [31:0] a, logic [31:0] b, logic [3:0] c);
    case (c)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return {31'd0, $signed(a) < $signed(b)};
      4'd6: return {31'd0, a < b};
      4'd7: return a << b[4:0];
      4'd8: return a >> b[4:0];
      4'd9: return $signed(a) >>> b[4:0];
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic ref_br(logic [31:0] a, logic [31:0] b, logic [2:0] br);
    case (br)
      3'b000: return a == b;
      3'b001: return a != b;
      3'b100: return $signed(a) < $signed(b);
      3'b101: return $signed(a) >= $signed(b);
      3'b110: return a < b;
      3'b111: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  // the shared ALU
  always_comb begin
    alu_res = ref_alu(alu_a, alu_b, alu_c);
    alu_tk  = ref_br(alu_a, alu_b, alu_br);
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_req(int n, logic val, logic [31:0] a, logic [31:0] b,
                         logic [3:0] c, logic [2:0] br);
    v[n] = val; sa[n] = a; sb[n] = b; ct[n] = c; bc[n] = br;
  endtask

  // one clock: check everything mid-cycle, then advance the model on the edge
  task automatic cycle();
    int  w;
    bit  gv, acc;
    @(negedge clk);
    gv  = v[0] || v[1];
    w   = (v[0] && v[1]) ? int'(m_rr) : (v[1] ? 1 : 0);
    acc = !m_full || rdy;
    ob_r0 = r0; ob_r1 = r1;
    chk("ready0", {31'd0, r0}, {31'd0, gv && acc && w == 0});
    chk("ready1", {31'd0, r1}, {31'd0, gv && acc && w == 1});
    chk("alu_a", alu_a, gv ? sa[w] : 32'd0);
    chk("alu_b", alu_b, gv ? sb[w] : 32'd0);
    chk("alu_ctrl", {28'd0, alu_c}, {28'd0, gv ? ct[w] : 4'b0000});
    chk("alu_branch", {29'd0, alu_br}, {29'd0, gv ? bc[w] : 3'b010});
    chk("resp_valid", {31'd0, resp_v}, {31'd0, m_full});
    chk("resp_id", {31'd0, resp_id}, {31'd0, m_id});
    chk("resp_result", resp_res, m_res);
    chk("resp_taken", {31'd0, resp_tk}, {31'd0, m_taken});
    @(posedge clk);
    last_hs = -1;
    if (gv && acc) begin
      last_hs = w;
      m_full  = 1'b1;
      m_id    = w[0];
      m_res   = ref_alu(sa[w], sb[w], ct[w]);
      m_taken = ref_br(sa[w], sb[w], bc[w]);
      m_rr    = (w == 0);
    end else if (m_full && rdy) begin
      m_full = 1'b0;
    end
    #1;
  endtask

  task automatic model_reset();
    m_full = 0; m_id = 0; m_taken = 0; m_rr = 0; m_res = '0; last_hs = -1;
  endtask

  task automatic do_reset();
    v[0] = 0; v[1] = 0;
    rst_n = 1'b0;
    #1;
    chk("rst_valid", {31'd0, resp_v}, 32'd0);
    chk("rst_id", {31'd0, resp_id}, 32'd0);
    chk("rst_result", resp_res, 32'd0);
    chk("rst_taken", {31'd0, resp_tk}, 32'd0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic rand_req(int n);
    set_req(n, 1'($urandom_range(0, 1)), $urandom, $urandom,
            4'($urandom_range(0, 9)), 3'($urandom_range(0, 7)));
  endtask

  logic [31:0] snap_res;
  logic        snap_id, snap_tk, prev_id;

  initial begin
    for (int n = 0; n < 2; n++) set_req(n, 0, '0, '0, '0, '0);
    rdy = 1'b1;
    model_reset();
    @(posedge clk); #1;
    chk("rst_alu_branch", {29'd0, alu_br}, {29'd0, 3'b010});
    do_reset();
    cycle();

    // single ADD
    set_req(0, 1, 32'd5, 32'd7, 4'd0, 3'b010);
    cycle();
    chk("t1_ready0", {31'd0, ob_r0}, 32'd1);
    v[0] = 0;
    chk("t1_result", resp_res, 32'd12);
    chk("t1_id", {31'd0, resp_id}, 32'd0);
    chk("t1_valid", {31'd0, resp_v}, 32'd1);
    cycle();
    chk("t1_drain", {31'd0, resp_v}, 32'd0);

    // simultaneous after reset
    do_reset();
    set_req(0, 1, 32'd9, 32'd4, 4'd1, 3'b010);
    set_req(1, 1, 32'hF0, 32'hFF, 4'd4, 3'b010);
    cycle();
    v[0] = 0;
    chk("t2_res0", resp_res, 32'd5);
    chk("t2_id0", {31'd0, resp_id}, 32'd0);
    cycle();
    v[1] = 0;
    chk("t2_res1", resp_res, 32'h0F);
    chk("t2_id1", {31'd0, resp_id}, 32'd1);
    cycle();

    // back-pressure with drain-and-fill
    set_req(0, 1, 32'd100, 32'd1, 4'd0, 3'b010);
    cycle();
    v[0] = 0;
    set_req(1, 1, 32'd3, 32'd2, 4'd7, 3'b010);
    rdy = 0;
    snap_res = resp_res; snap_id = resp_id; snap_tk = resp_tk;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("bp_ready1", {31'd0, ob_r1}, 32'd0);
      chk("bp_hold_res", resp_res, snap_res);
      chk("bp_hold_id", {31'd0, resp_id}, {31'd0, snap_id});
      chk("bp_hold_tk", {31'd0, resp_tk}, {31'd0, snap_tk});
    end
    rdy = 1;
    cycle();
    chk("bp_fill_ready1", {31'd0, ob_r1}, 32'd1);
    chk("bp_fill_res", resp_res, 32'd12);
    chk("bp_fill_valid", {31'd0, resp_v}, 32'd1);
    v[1] = 0;
    cycle();

    // streaming contention
    rand_req(0); rand_req(1); v[0] = 1; v[1] = 1;
    cycle();
    prev_id = resp_id;
    for (int i = 1; i < 8; i++) begin
      if (last_hs >= 0) begin rand_req(last_hs); v[last_hs] = 1; end
      cycle();
      chk("stream_valid", {31'd0, resp_v}, 32'd1);
      chk("stream_alt", {31'd0, resp_id}, {31'd0, ~prev_id});
      prev_id = resp_id;
    end
    v[0] = 0; v[1] = 0;
    cycle();

    // branch path
    set_req(1, 1, 32'hFFFFFFFF, 32'd1, 4'd0, 3'b100);
    cycle();
    chk("blt_taken", {31'd0, resp_tk}, 32'd1);
    bc[1] = 3'b110;
    cycle();
    chk("bltu_taken", {31'd0, resp_tk}, 32'd0);
    bc[1] = 3'b010;
    cycle();
    chk("nobr_taken", {31'd0, resp_tk}, 32'd0);
    v[1] = 0;
    cycle();

    // reset while a response is held and rr points at requester 1
    do_reset();
    set_req(0, 1, 32'd1, 32'd2, 4'd0, 3'b010);
    cycle();
    v[0] = 0; rdy = 0;
    chk("mid_pre_valid", {31'd0, resp_v}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_valid", {31'd0, resp_v}, 32'd0);
    chk("mid_id", {31'd0, resp_id}, 32'd0);
    chk("mid_result", resp_res, 32'd0);
    chk("mid_taken", {31'd0, resp_tk}, 32'd0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1; rdy = 1;
    set_req(0, 1, 32'd20, 32'd22, 4'd0, 3'b010);
    set_req(1, 1, 32'd7, 32'd7, 4'd0, 3'b000);
    cycle();
    chk("mid_first_grant0", {31'd0, ob_r0}, 32'd1);
    chk("mid_first_res", resp_res, 32'd42);
    v[0] = 0; v[1] = 0;
    cycle();

    // randomized traffic; a stalled requester holds its operation
    for (int i = 0; i < 400; i++) begin
      for (int n = 0; n < 2; n++)
        if (!(v[n] && last_hs != n)) rand_req(n);
      rdy = 1'($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
